// File: rtl/pc_branch_ctrl.sv
// PC register, flag register and branch resolution for the fetch/decode pair.
// Branches wait one extra cycle when the EX instruction is still writing flags.
module pc_branch_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_in,
   input  logic        halt,
   input  logic        br_valid,
   input  logic        br_reg,
   input  logic [2:0]  cond,
   input  logic [8:0]  imm,
   input  logic [15:0] reg_tgt,
   input  logic [15:0] id_pc_plus2,
   input  logic        ex_flag_pending,
   input  logic [2:0]  flag_we,
   input  logic [2:0]  alu_flags,
   output logic [15:0] pc,
   output logic [15:0] pc_plus2,
   output logic        flush,
   output logic        stall_out,
   output logic [2:0]  flags,
   output logic        halted
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FWAIT = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [15:0] pc_nx;
   logic [15:0] off;
   logic [15:0] tgt;
   logic [2:0]  flags_nx;
   logic        taken;
   logic        fz;
   logic        fv;
   logic        fn;

   assign pc_plus2 = pc + 16'd2;
   assign halted   = (state == HALT);
   assign {fz, fv, fn} = flags;

   // Word offset: sign-extend and scale to bytes.
   assign off = {{6{imm[8]}}, imm, 1'b0};
   assign tgt = br_reg ? reg_tgt : (id_pc_plus2 + off);

   assign flags_nx = (flags & ~flag_we) | (alu_flags & flag_we);

   always_comb begin
      taken = 1'b0;
      unique case (cond)
         3'b000: taken = ~fz;
         3'b001: taken = fz;
         3'b010: taken = ~fz & ~fn;
         3'b011: taken = fn;
         3'b100: taken = ~fn;
         3'b101: taken = fz | fn;
         3'b110: taken = fv;
         3'b111: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      flush     = 1'b0;
      stall_out = 1'b0;
      unique case (state)
         RUN: begin
            if (!stall_in) begin
               if (halt) begin
                  state_nx = HALT;
               end else if (br_valid) begin
                  if (ex_flag_pending) begin
                     stall_out = 1'b1;
                     state_nx  = FWAIT;
                  end else if (taken) begin
                     flush = 1'b1;
                     pc_nx = tgt;
                  end else begin
                     pc_nx = pc_plus2;
                  end
               end else begin
                  pc_nx = pc_plus2;
               end
            end
         end
         FWAIT: begin
            if (!stall_in) begin
               state_nx = RUN;
               if (taken) begin
                  flush = 1'b1;
                  pc_nx = tgt;
               end else begin
                  pc_nx = pc_plus2;
               end
            end
         end
         HALT: begin
            state_nx = HALT;
         end
         default: begin
            state_nx = RUN;
         end
      endcase
      // Nothing leaves this block while reset is being applied.
      if (!rst_n) begin
         flush     = 1'b0;
         stall_out = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
         pc    <= 16'h0000;
         flags <= 3'b000;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         flags <= flags_nx;
      end
   end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed bench for pc_branch_ctrl with a queue of expected outputs.
module tb_pc_branch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        stall_in;
   logic        halt;
   logic        br_valid;
   logic        br_reg;
   logic [2:0]  cond;
   logic [8:0]  imm;
   logic [15:0] reg_tgt;
   logic [15:0] id_pc_plus2;
   logic        ex_flag_pending;
   logic [2:0]  flag_we;
   logic [2:0]  alu_flags;
   logic [15:0] pc;
   logic [15:0] pc_plus2;
   logic        flush;
   logic        stall_out;
   logic [2:0]  flags;
   logic        halted;

   typedef struct {
      int          sel;
      logic [15:0] val;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   pc_branch_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall_in        (stall_in),
      .halt            (halt),
      .br_valid        (br_valid),
      .br_reg          (br_reg),
      .cond            (cond),
      .imm             (imm),
      .reg_tgt         (reg_tgt),
      .id_pc_plus2     (id_pc_plus2),
      .ex_flag_pending (ex_flag_pending),
      .flag_we         (flag_we),
      .alu_flags       (alu_flags),
      .pc              (pc),
      .pc_plus2        (pc_plus2),
      .flush           (flush),
      .stall_out       (stall_out),
      .flags           (flags),
      .halted          (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall_in        = 1'b0;
      halt            = 1'b0;
      br_valid        = 1'b0;
      br_reg          = 1'b0;
      cond            = 3'b000;
      imm             = 9'h000;
      reg_tgt         = 16'h0000;
      id_pc_plus2     = 16'h0000;
      ex_flag_pending = 1'b0;
      flag_we         = 3'b000;
      alu_flags       = 3'b000;
   endtask

   task automatic want(input int sel, input logic [15:0] val,
                       input string tag);
      exp_t e;
      e.sel = sel;
      e.val = val;
      e.tag = tag;
      sb.push_back(e);
   endtask

   function automatic logic [15:0] obs(input int sel);
      case (sel)
         0: return pc;
         1: return {15'd0, flush};
         2: return {15'd0, stall_out};
         3: return {13'd0, flags};
         4: return {15'd0, halted};
         default: return pc_plus2;
      endcase
   endfunction

   task automatic check();
      exp_t        e;
      logic [15:0] o;
      #3;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs(e.sel);
         checks++;
         assert (o === e.val) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
         end
      end
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      tick();
      want(1, 16'h0, "rst_flush");
      want(2, 16'h0, "rst_stall");
      check();
      tick();
      want(0, 16'h0000, "rst_pc");
      want(4, 16'h0, "rst_halted");
      want(3, 16'h0, "rst_flags");
      check();
      rst_n = 1'b1;

      tick();
      want(0, 16'h0002, "idle_pc1");
      want(5, 16'h0004, "idle_pcp2");
      check();
      tick();
      want(0, 16'h0004, "idle_pc2");
      check();
      tick();
      want(0, 16'h0006, "idle_pc3");
      want(3, 16'h0, "idle_flags");
      check();

      flag_we   = 3'b100;
      alu_flags = 3'b111;
      tick();
      idle();
      want(3, 16'h4, "set_z");
      want(0, 16'h0008, "set_z_pc");
      check();

      br_valid    = 1'b1;
      cond        = 3'b001;
      imm         = 9'h1FE;
      id_pc_plus2 = 16'h0010;
      want(1, 16'h1, "b_taken_flush");
      want(2, 16'h0, "b_taken_stall");
      check();
      tick();
      idle();
      want(0, 16'h000C, "b_taken_pc");
      want(1, 16'h0, "b_taken_flush_off");
      check();

      flag_we = 3'b100;
      tick();
      idle();
      want(3, 16'h0, "clr_z");
      check();

      br_valid        = 1'b1;
      cond            = 3'b010;
      imm             = 9'h010;
      id_pc_plus2     = 16'h0020;
      ex_flag_pending = 1'b1;
      flag_we         = 3'b001;
      alu_flags       = 3'b001;
      want(2, 16'h1, "fw_stall");
      want(1, 16'h0, "fw_flush0");
      want(0, 16'h000E, "fw_pc0");
      check();
      tick();
      flag_we   = 3'b000;
      alu_flags = 3'b000;
      want(2, 16'h0, "fw_stall_off");
      want(1, 16'h0, "fw_flush1");
      want(3, 16'h1, "fw_flags");
      want(0, 16'h000E, "fw_pc_held");
      check();
      tick();
      idle();
      want(0, 16'h0010, "fw_pc_adv");
      check();

      br_valid = 1'b1;
      br_reg   = 1'b1;
      cond     = 3'b111;
      reg_tgt  = 16'hFFFE;
      want(1, 16'h1, "br_flush");
      check();
      tick();
      idle();
      want(0, 16'hFFFE, "br_pc");
      check();
      tick();
      want(0, 16'h0000, "wrap_pc");
      check();

      br_valid    = 1'b1;
      cond        = 3'b111;
      imm         = 9'h004;
      id_pc_plus2 = 16'h0040;
      stall_in    = 1'b1;
      want(1, 16'h0, "stl_flush0");
      want(2, 16'h0, "stl_stall0");
      check();
      tick();
      want(0, 16'h0000, "stl_pc1");
      want(1, 16'h0, "stl_flush1");
      check();
      tick();
      stall_in = 1'b0;
      want(0, 16'h0000, "stl_pc2");
      want(1, 16'h1, "stl_resolve");
      check();
      tick();
      idle();
      want(0, 16'h0048, "stl_pc_tgt");
      check();

      halt     = 1'b1;
      br_valid = 1'b1;
      cond     = 3'b111;
      want(1, 16'h0, "hlt_prio_flush");
      check();
      tick();
      idle();
      want(4, 16'h1, "hlt_halted");
      want(0, 16'h0048, "hlt_pc");
      check();
      for (int i = 0; i < 5; i++) begin
         br_valid = 1'b1;
         cond     = 3'b111;
         tick();
         want(0, 16'h0048, $sformatf("hlt_frozen%0d", i));
         want(1, 16'h0, $sformatf("hlt_flush%0d", i));
         check();
      end
      idle();
      flag_we   = 3'b111;
      alu_flags = 3'b110;
      tick();
      idle();
      want(3, 16'h6, "hlt_flag_wr");
      check();

      rst_n    = 1'b0;
      br_valid = 1'b1;
      cond     = 3'b111;
      want(1, 16'h0, "rst2_flush");
      check();
      tick();
      idle();
      want(0, 16'h0000, "rst2_pc");
      want(4, 16'h0, "rst2_halted");
      want(3, 16'h0, "rst2_flags");
      check();
      rst_n = 1'b1;
      tick();
      want(0, 16'h0002, "rst2_run");
      check();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_branch_ctrl.md
PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
REQ-003 SHALL have port stall_in  input  1  hazard-unit stall; the ID instruction is held.
REQ-004 SHALL have port halt  input  1  ID instruction is HLT.
REQ-005 SHALL have port br_valid  input  1  ID instruction is a branch (B or BR).
REQ-006 SHALL have port br_reg  input  1  1 = BR (register target), 0 = B (PC-relative).
REQ-007 SHALL have port cond  input  3  branch condition code.
REQ-008 SHALL have port imm  input  9  signed word offset for B.
REQ-009 SHALL have port reg_tgt  input  16  target address for BR.
REQ-010 SHALL have port id_pc_plus2  input  16  PC+2 of the ID instruction.
REQ-011 SHALL have port ex_flag_pending  input  1  the EX instruction writes flags this cycle.
REQ-012 SHALL have port flag_we  input  3  per-flag write enables {Z,V,N}.
REQ-013 SHALL have port alu_flags  input  3  ALU flag results {Z,V,N}.
REQ-014 SHALL have port pc  output  16  fetch address (registered).
REQ-015 SHALL have port pc_plus2  output  16  pc + 2, combinational, modulo 2^16.
REQ-016 SHALL have port flush  output  1  kill the IF instruction (taken branch).
REQ-017 SHALL have port stall_out  output  1  hold IF/ID (flag wait).
REQ-018 SHALL have port flags  output  3  registered {Z,V,N}.
REQ-019 SHALL have port halted  output  1  core halted.

Function
REQ-020 SHALL implement the states RUN, FWAIT and HALT.
REQ-021 SHALL update each flag bit on the clock edge only when its flag_we bit is 1, and SHALL hold it otherwise.
REQ-022 SHALL evaluate the condition from the registered flags: 000 ~Z; 001 Z; 010 ~Z&~N; 011 N; 100 ~N; 101 Z|N; 110 V; 111 always taken.
REQ-023 SHALL compute the target as reg_tgt when br_reg = 1, else id_pc_plus2 + (sext(imm) << 1), with 16-bit wrap-around.
REQ-024 In RUN with stall_in = 1: pc SHALL hold, with no resolution, flush = 0 and stall_out = 0.
REQ-025 In RUN with br_valid = 1 and ex_flag_pending = 1: stall_out = 1 combinationally, pc SHALL hold, and the next state SHALL be FWAIT.
REQ-026 In RUN with br_valid = 1 and ex_flag_pending = 0, the branch SHALL resolve in that cycle.
REQ-027 On a taken resolution: flush = 1 for exactly that cycle, and pc SHALL become the target at the next edge.
REQ-028 On a not-taken resolution: flush = 0, and pc SHALL become pc_plus2.
REQ-029 In RUN with no branch and no stall, pc SHALL become pc_plus2.
REQ-030 FWAIT SHALL last one cycle and resolve the branch per REQ-026 to REQ-028 using the updated flags, then return to RUN.
REQ-031 In FWAIT, stall_in = 1 SHALL keep the state in FWAIT with pc held.
REQ-032 In FWAIT, ex_flag_pending SHALL be ignored.
REQ-033 halt = 1 with stall_in = 0 SHALL enter HALT at the next edge with pc held; halt SHALL take priority over br_valid.
REQ-034 HALT SHALL drive halted = 1, freeze pc, and keep flush = 0 and stall_out = 0 until reset.
REQ-035 Flag writes SHALL continue in every state, including HALT, so in-flight instructions drain.
REQ-036 Branch resolution SHALL have zero added latency when no flag hazard exists, and exactly one added cycle otherwise.

Reset
REQ-037 While rst_n = 0 at a clock edge: pc = 0x0000, flags = 000, state = RUN, halted = 0.
REQ-038 flush and stall_out SHALL be 0 during the reset cycle.
REQ-039 Reset SHALL abort FWAIT or HALT immediately, and any pending branch SHALL be discarded.

Verification
REQ-040 Bench SHALL cover: reset, then 3 idle cycles -> pc sequence 0x0000, 0x0002, 0x0004, 0x0006; flags = 000.
REQ-041 Bench SHALL cover: flags Z = 1, B cond 001, imm = 0x1FE (-2), id_pc_plus2 = 0x0010 -> flush = 1 for one cycle; next pc = 0x000C.
REQ-042 Bench SHALL cover: br_valid, cond 010, ex_flag_pending = 1 with alu_flags N = 1 written -> stall_out = 1 one cycle; FWAIT resolves not-taken; flush = 0; pc advances by 2.
REQ-043 Bench SHALL cover: BR cond 111, reg_tgt = 0xFFFE, then 1 idle cycle -> pc = 0xFFFE, then 0x0000 (wrap).
REQ-044 Bench SHALL cover: branch with stall_in = 1 for 2 cycles -> pc held and flush = 0 throughout; it resolves on the first cycle with stall_in = 0.
REQ-045 Bench SHALL cover: halt = 1 and br_valid = 1 together -> HALT; halted = 1; pc frozen for 5 cycles; rst_n = 0 -> pc = 0x0000 and halted = 0.
